calc_sequencer: RTL and testbench

Sequencing controller for the hex keypad calculator. It consumes the one-cycle strobes decoded from the keypad (hex digit, operator, equals, backspace) and builds operands digit by digit. It holds the pending operator, performs add/multiply/subtract on the accumulator, and drives a registered display value plus an overflow flag to the seven-segment display path. Evaluation is strictly left-to-right, with no operator precedence.

---
 rtl/calc_sequencer.sv | 148 ++++++++++++++
 tb/tb_calc_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// Keypad calculator sequencer: builds hex operands from key strobes, holds the
// pending operator and evaluates add/mul/sub strictly left to right.
module calc_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             newhex,
  input  logic [3:0]       hexcode,
  input  logic             newop,
  input  logic [1:0]       opcode,
  input  logic             eq,
  input  logic             BS,
  output logic [WIDTH-1:0] display,
  output logic             overflow,
  output logic [1:0]       mode
);

  typedef enum logic [1:0] {
    ENTRY_A = 2'b00,
    OP_WAIT = 2'b01,
    ENTRY_B = 2'b10,
    RESULT  = 2'b11
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_entry;
  logic [WIDTH-1:0] r_acc;
  logic [1:0]       r_op;

  // Single event per cycle: eq > BS > operator > hex
  logic w_ev_eq, w_ev_bs, w_ev_op, w_ev_hex;
  assign w_ev_eq  = eq;
  assign w_ev_bs  = BS & ~eq;
  assign w_ev_op  = newop & ~eq & ~BS;
  assign w_ev_hex = newhex & ~eq & ~BS & ~newop;

  logic [WIDTH-1:0] w_shift, w_bs_entry, w_hexz;
  logic             w_full;
  assign w_shift    = {r_entry[WIDTH-5:0], hexcode};
  assign w_bs_entry = r_entry >> 4;
  assign w_hexz     = {{(WIDTH-4){1'b0}}, hexcode};
  assign w_full     = |r_entry[WIDTH-1:WIDTH-4];

  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_res;
  logic               w_ovf;

  always_comb begin
    w_sum  = {1'b0, r_acc} + {1'b0, r_entry};
    w_prod = {{WIDTH{1'b0}}, r_acc} * {{WIDTH{1'b0}}, r_entry};
    w_res  = w_sum[WIDTH-1:0];
    w_ovf  = w_sum[WIDTH];
    case (r_op)
      2'b01: begin
        w_res = w_prod[WIDTH-1:0];
        w_ovf = |w_prod[2*WIDTH-1:WIDTH];
      end
      2'b10: begin
        w_res = r_acc - r_entry;
        w_ovf = (r_acc < r_entry);
      end
      default: ;
    endcase
  end

  assign mode = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ENTRY_A;
      r_entry  <= '0;
      r_acc    <= '0;
      r_op     <= 2'b00;
      display  <= '0;
      overflow <= 1'b0;
    end else begin
      case (r_state)
        ENTRY_A, ENTRY_B: begin
          if (w_ev_eq) begin
            r_state <= RESULT;
            if (r_state == ENTRY_A) begin
              r_acc    <= r_entry;
              overflow <= 1'b0;
              display  <= r_entry;
            end else begin
              r_acc    <= w_res;
              overflow <= w_ovf;
              display  <= w_res;
            end
          end else if (w_ev_bs) begin
            r_entry <= w_bs_entry;
            display <= w_bs_entry;
          end else if (w_ev_op) begin
            r_op    <= opcode;
            r_state <= OP_WAIT;
            // ENTRY_B chains: fold the pending operation before taking the new one
            if (r_state == ENTRY_A) begin
              r_acc   <= r_entry;
              display <= r_entry;
            end else begin
              r_acc    <= w_res;
              overflow <= w_ovf;
              display  <= w_res;
            end
          end else if (w_ev_hex && !w_full) begin
            r_entry <= w_shift;
            display <= w_shift;
          end
        end
        OP_WAIT: begin
          if (w_ev_bs) begin
            r_entry <= r_acc;
            display <= r_acc;
            r_state <= ENTRY_A;
          end else if (w_ev_op) begin
            r_op <= opcode;
          end else if (w_ev_hex) begin
            r_entry <= w_hexz;
            display <= w_hexz;
            r_state <= ENTRY_B;
          end
        end
        RESULT: begin
          if (w_ev_bs) begin
            r_state  <= ENTRY_A;
            r_entry  <= '0;
            r_acc    <= '0;
            r_op     <= 2'b00;
            display  <= '0;
            overflow <= 1'b0;
          end else if (w_ev_op) begin
            r_op    <= opcode;
            r_state <= OP_WAIT;
          end else if (w_ev_hex) begin
            r_entry  <= w_hexz;
            display  <= w_hexz;
            overflow <= 1'b0;
            r_state  <= ENTRY_A;
          end
        end
        default: r_state <= ENTRY_A;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed test-plan sequences plus random key
// streams, all compared against an arithmetic model of the calculator.
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        reset, newhex, newop, eq, BS;
  logic [3:0]  hexcode;
  logic [1:0]  opcode;
  logic [15:0] display;
  logic        overflow;
  logic [1:0]  mode;

  int n_chk  = 0;
  int n_fail = 0;

  calc_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .newhex(newhex), .hexcode(hexcode),
    .newop(newop), .opcode(opcode), .eq(eq), .BS(BS),
    .display(display), .overflow(overflow), .mode(mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Model: phase 0=first operand, 1=operator chosen, 2=second operand, 3=result
  int          m_ph;
  int unsigned m_entry, m_acc;
  int          m_op;
  bit          m_ovf;

  task automatic m_reset();
    m_ph = 0; m_entry = 0; m_acc = 0; m_op = 0; m_ovf = 0;
  endtask

  task automatic m_eval(output int unsigned r, output bit o);
    longint unsigned p;
    case (m_op)
      1: begin p = longint'(m_acc) * longint'(m_entry); r = int'(p % 65536); o = (p > 65535); end
      2: begin o = (m_acc < m_entry); r = (m_acc + 65536 - m_entry) % 65536; end
      default: begin r = (m_acc + m_entry) % 65536; o = (m_acc + m_entry) > 65535; end
    endcase
  endtask

  task automatic m_step(input bit rst, nh, input int hc, input bit no, input int oc, input bit e, b);
    int unsigned r;
    bit o;
    if (rst) begin m_reset(); return; end
    if (e) begin
      if (m_ph == 0) begin m_acc = m_entry; m_ovf = 0; m_ph = 3; end
      else if (m_ph == 2) begin m_eval(r, o); m_acc = r; m_ovf = o; m_ph = 3; end
    end else if (b) begin
      if (m_ph == 0 || m_ph == 2) m_entry = m_entry / 16;
      else if (m_ph == 1) begin m_entry = m_acc; m_ph = 0; end
      else m_reset();
    end else if (no) begin
      if (m_ph == 0) m_acc = m_entry;
      else if (m_ph == 2) begin m_eval(r, o); m_acc = r; m_ovf = o; end
      m_op = oc; m_ph = 1;
    end else if (nh) begin
      if (m_ph == 0 || m_ph == 2) begin
        if (m_entry < 16'h1000) m_entry = m_entry * 16 + hc;
      end else if (m_ph == 1) begin m_entry = hc; m_ph = 2; end
      else begin m_entry = hc; m_ovf = 0; m_ph = 0; end
    end
  endtask

  task automatic step(input bit rst, nh, input int hc, input bit no, input int oc, input bit e, b);
    reset = rst; newhex = nh; hexcode = 4'(hc); newop = no; opcode = 2'(oc); eq = e; BS = b;
    m_step(rst, nh, hc, no, oc, e, b);
    @(posedge clk); #1;
    reset = 0; newhex = 0; newop = 0; eq = 0; BS = 0;
    chk("display", 32'(display), (m_ph == 0 || m_ph == 2) ? m_entry : m_acc);
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("mode", 32'(mode), 32'(m_ph));
  endtask

  task automatic rst_k();            step(1, 0, 0, 0, 0, 0, 0); endtask
  task automatic hex(input int d);   step(0, 1, d, 0, 0, 0, 0); endtask
  task automatic opk(input int o);   step(0, 0, 0, 1, o, 0, 0); endtask
  task automatic eqk();              step(0, 0, 0, 1, 0, 1, 0); endtask
  task automatic bsk();              step(0, 0, 0, 1, 0, 0, 1); endtask

  initial begin
    reset = 1; newhex = 0; hexcode = 0; newop = 0; opcode = 0; eq = 0; BS = 0;
    m_reset();
    @(posedge clk); #1;
    chk("rst_display", 32'(display), 0);
    chk("rst_mode", 32'(mode), 0);
    chk("rst_ovf", 32'(overflow), 0);

    // 12 + 3 = 15
    rst_k(); hex(1); hex(2); chk("tp1_a", 32'(display), 32'h12);
    opk(0); chk("tp1_opw", 32'(display), 32'h12);
    hex(3); chk("tp1_b", 32'(display), 32'h3);
    eqk(); chk("tp1_res", 32'(display), 32'h15); chk("tp1_mode", 32'(mode), 3);

    // 3 - 5 wraps, then a new digit starts a fresh calculation
    rst_k(); hex(3); opk(2); hex(5); eqk();
    chk("sub_res", 32'(display), 32'hFFFE); chk("sub_ovf", 32'(overflow), 1);
    hex(7); chk("new_disp", 32'(display), 32'h7); chk("new_ovf", 32'(overflow), 0);
    chk("new_mode", 32'(mode), 0);

    // 0x100 * 0x100, then digit limit and backspace
    rst_k(); hex(1); hex(0); hex(0); opk(1); hex(1); hex(0); hex(0); eqk();
    chk("mul_res", 32'(display), 0); chk("mul_ovf", 32'(overflow), 1);
    hex(1); hex(2); hex(3); hex(4); hex(5);
    chk("digit_lim", 32'(display), 32'h1234);
    bsk(); chk("bs", 32'(display), 32'h123);

    // Chaining and operator replacement
    rst_k(); hex(2); opk(0); hex(3); opk(1); chk("chain_mid", 32'(display), 32'h5);
    hex(4); eqk(); chk("chain_res", 32'(display), 32'h14);
    rst_k(); hex(9); opk(0); opk(2); hex(2); eqk(); chk("op_repl", 32'(display), 32'h7);

    // Simultaneous strobes
    rst_k(); hex(1); opk(0); hex(1); step(0, 0, 0, 1, 0, 1, 0);
    chk("eq_op_disp", 32'(display), 32'h2); chk("eq_op_mode", 32'(mode), 3);
    rst_k(); hex(5); opk(0); step(0, 0, 0, 1, 1, 0, 1);
    chk("bs_op_mode", 32'(mode), 0); chk("bs_op_disp", 32'(display), 32'h5);

    // Reset beats a strobe mid-calculation
    rst_k(); hex(1); opk(0); hex(2); step(1, 1, 7, 0, 0, 0, 0);
    chk("midrst_disp", 32'(display), 0); chk("midrst_mode", 32'(mode), 0);
    eqk(); chk("midrst_eq", 32'(display), 0);

    // Random key streams, including overlapping strobes and occasional reset
    for (int i = 0; i < 3000; i++) begin
      int k;
      k = int'($urandom_range(0, 99));
      if (k < 2)       step(1, 0, 0, 0, 0, 0, 0);
      else if (k < 50) step(0, 1, int'($urandom_range(0, 15)), 0, 0, 0, 0);
      else if (k < 65) step(0, 0, 0, 1, int'($urandom_range(0, 3)), 0, 0);
      else if (k < 75) eqk();
      else if (k < 80) bsk();
      else if (k < 90) step(0, 0, 0, 0, 0, 0, 0);
      else step(0, 1'($urandom), int'($urandom_range(0, 15)), 1'($urandom),
                int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
